// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : round-robin arbiter sharing one single-port data SRAM
//                between the core (port A) and the loader/debug port (port B)
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic [DW/8-1:0] a_wen,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  output logic            a_gnt,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_req,
  input  logic [DW/8-1:0] b_wen,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  output logic            b_gnt,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd,
  output logic            last_b
);

  localparam int c_BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_b;
  logic [DW-1:0]   r_a_rdata;
  logic [DW-1:0]   r_b_rdata;
  logic            w_a_gnt;
  logic            w_b_gnt;
  logic [c_BW-1:0] w_mem_wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_b <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_a_gnt)
        r_last_b <= 1'b0;
      else if (w_b_gnt)
        r_last_b <= 1'b1;
    end
  end

  // Grants are gated by rst_n so nothing reaches the SRAM while reset is held.
  always_comb begin
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    w_mem_wen   = '0;
    w_state_nxt = IDLE;
    if (rst_n) begin
      w_a_gnt = a_req & (~b_req | r_last_b);
      w_b_gnt = b_req & (~a_req | ~r_last_b);
    end
    if (w_a_gnt) begin
      w_mem_wen = a_wen;
      if (a_wen == '0)
        w_state_nxt = RD_A;
    end else if (w_b_gnt) begin
      w_mem_wen = b_wen;
      if (b_wen == '0)
        w_state_nxt = RD_B;
    end
  end

  // Last returned word per port is kept so rdata stays stable between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (r_state == RD_A)
        r_a_rdata <= mem_rd;
      if (r_state == RD_B)
        r_b_rdata <= mem_rd;
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign mem_en   = w_a_gnt | w_b_gnt;
  assign mem_wen  = w_mem_wen;
  assign mem_addr = w_b_gnt ? b_addr  : a_addr;
  assign mem_wd   = w_b_gnt ? b_wdata : a_wdata;
  assign a_rvalid = (r_state == RD_A);
  assign b_rvalid = (r_state == RD_B);
  assign a_rdata  = (r_state == RD_A) ? mem_rd : r_a_rdata;
  assign b_rdata  = (r_state == RD_B) ? mem_rd : r_b_rdata;
  assign last_b   = r_last_b;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter
// Revision        : 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          a_req, b_req;
  logic [3:0]    a_wen, b_wen;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          last_b;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total;
  int bad;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .last_b(last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM model: byte-masked write, registered read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen == 4'b0000)
        mem_rd <= mem[mem_addr];
      else
        for (int k = 0; k < 4; k++)
          if (mem_wen[k]) mem[mem_addr][k*8 +: 8] <= mem_wd[k*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_wen = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_wen = 0; b_addr = 0; b_wdata = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mem_rd = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[1] = 32'h0000_0001;
    mem[2] = 32'h0000_0002;
    mem[3] = 32'h1122_3344;
    mem[5] = 32'hDEAD_BEEF;
    idle_inputs();

    // Reset with both requests active: nothing may be granted
    rst_n = 0;
    a_req = 1; b_req = 1;
    tick(); tick();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_last_b", last_b, 1);

    // Single A read in the first cycle after reset release
    idle_inputs();
    rst_n = 1;
    a_req = 1; a_addr = 5;
    #1;
    chk("rd5_a_gnt", a_gnt, 1);
    chk("rd5_b_gnt", b_gnt, 0);
    chk("rd5_mem_en", mem_en, 1);
    chk("rd5_mem_addr", mem_addr, 5);
    chk("rd5_mem_wen", mem_wen, 0);
    tick();
    idle_inputs();
    #1;
    chk("rd5_a_rvalid", a_rvalid, 1);
    chk("rd5_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("rd5_b_rvalid", b_rvalid, 0);
    chk("rd5_last_b", last_b, 0);
    chk("rd5_idle_mem_en", mem_en, 0);
    tick();
    chk("rd5_rvalid_once", a_rvalid, 0);
    chk("rd5_rdata_held", a_rdata, 32'hDEAD_BEEF);

    // Contention straight after reset: A first, then strict alternation
    rst_n = 0;
    tick();
    rst_n = 1;
    a_req = 1; a_addr = 1;
    b_req = 1; b_addr = 2;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("alt%0d_a_gnt", i), a_gnt, (i % 2 == 0));
      chk($sformatf("alt%0d_b_gnt", i), b_gnt, (i % 2 == 1));
      if (i > 0) begin
        chk($sformatf("alt%0d_a_rvalid", i), a_rvalid, (i % 2 == 1));
        chk($sformatf("alt%0d_b_rvalid", i), b_rvalid, (i % 2 == 0));
      end
      tick();
    end
    idle_inputs();
    tick();

    // Byte write from B, then A reads the merged word
    b_req = 1; b_wen = 4'b0001; b_addr = 3; b_wdata = 32'h0000_00AA;
    #1;
    chk("bw_b_gnt", b_gnt, 1);
    chk("bw_mem_wen", mem_wen, 4'b0001);
    chk("bw_mem_addr", mem_addr, 3);
    chk("bw_mem_wd", mem_wd, 32'h0000_00AA);
    tick();
    idle_inputs();
    a_req = 1; a_addr = 3;
    #1;
    chk("bw_no_b_rvalid", b_rvalid, 0);
    chk("bw_no_a_rvalid", a_rvalid, 0);
    chk("bw_last_b", last_b, 1);
    chk("bwrd_a_gnt", a_gnt, 1);
    tick();
    idle_inputs();
    #1;
    chk("bwrd_a_rvalid", a_rvalid, 1);
    chk("bwrd_a_rdata", a_rdata, 32'h1122_33AA);
    tick();

    // Back-to-back reads: A addr 1, then B addr 2
    a_req = 1; a_addr = 1;
    #1;
    chk("b2b_a_gnt", a_gnt, 1);
    tick();
    idle_inputs();
    b_req = 1; b_addr = 2;
    #1;
    chk("b2b_b_gnt", b_gnt, 1);
    chk("b2b_a_rvalid", a_rvalid, 1);
    chk("b2b_a_rdata", a_rdata, 32'h0000_0001);
    tick();
    idle_inputs();
    #1;
    chk("b2b_b_rvalid", b_rvalid, 1);
    chk("b2b_b_rdata", b_rdata, 32'h0000_0002);
    chk("b2b_a_rvalid_off", a_rvalid, 0);
    chk("b2b_a_rdata_held", a_rdata, 32'h0000_0001);
    tick();

    // Reset arriving while an A read is pending
    a_req = 1; a_addr = 5;
    #1;
    chk("mid_a_gnt", a_gnt, 1);
    tick();
    idle_inputs();
    rst_n = 0;
    #1;
    chk("mid_a_rvalid", a_rvalid, 0);
    chk("mid_last_b", last_b, 1);
    chk("mid_mem_en", mem_en, 0);
    tick();
    rst_n = 1;
    #1;
    chk("mid_post_a_rvalid0", a_rvalid, 0);
    chk("mid_post_b_rvalid0", b_rvalid, 0);
    tick();
    chk("mid_post_a_rvalid1", a_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning the SRAM word address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width; byte-enable width is DW/8.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_req  input  1  port A (core execute stage) access request.
REQ-006 a_wen  input  DW/8  port A byte write enables; all-zero means read.
REQ-007 a_addr  input  AW  port A word address.
REQ-008 a_wdata  input  DW  port A write data.
REQ-009 a_gnt  output  1  port A request accepted this cycle.
REQ-010 a_rvalid  output  1  port A read data valid.
REQ-011 a_rdata  output  DW  port A read data.
REQ-012 b_req, b_wen, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata SHALL be identical in direction, width and meaning to the port A signals, for port B (loader/debug).
REQ-013 mem_en  output  1  SRAM access strobe.
REQ-014 mem_wen  output  DW/8  SRAM byte write enables.
REQ-015 mem_addr  output  AW  SRAM word address.
REQ-016 mem_wd  output  DW  SRAM write data.
REQ-017 mem_rd  input  DW  SRAM read data, valid one cycle after a read strobe.
REQ-018 last_b  output  1  round-robin pointer; 1 = port B won the most recent grant.

Function
REQ-019 The block SHALL issue at most one grant per cycle, with a_gnt and b_gnt combinational from the current req inputs and the registered pointer.
REQ-020 With only one request asserted, that port SHALL be granted in the same cycle.
REQ-021 With both requests asserted, the port not named by last_b SHALL be granted: A if last_b=1, B if last_b=0.
REQ-022 On each grant, last_b SHALL update at the next edge to the granted port; with no grant, last_b SHALL hold.
REQ-023 In a grant cycle, mem_en=1 and mem_addr/mem_wen/mem_wd SHALL equal the granted port's inputs.
REQ-024 With no grant, mem_en=0 and mem_wen=0; mem_addr and mem_wd are don't-care.
REQ-025 A granted read (wen=0) SHALL assert that port's rvalid for exactly one cycle, the cycle after the grant, with rdata=mem_rd.
REQ-026 A granted write SHALL NOT assert rvalid.
REQ-027 The block SHALL track the pending-read owner in a registered state: IDLE, RD_A, RD_B.
REQ-028 The pending-read state SHALL go to RD_A or RD_B on a read grant and to IDLE otherwise; it selects which rvalid to drive.
REQ-029 Back-to-back grants SHALL be allowed every cycle; a read followed by any access SHALL return correct data to the original requester.
REQ-030 A requester SHALL hold req and its address/data stable until gnt; the arbiter SHALL NOT queue requests.
REQ-031 A request dropped before gnt SHALL be ignored, with no state change.
REQ-032 rdata for a non-valid port SHALL be held at its last value, not required to be zero.
REQ-033 With continuous requests on both ports, the ports SHALL alternate grants with no starvation; maximum wait is one cycle.
REQ-034 Simultaneous a_req and b_req with either write or read mix SHALL follow REQ-021 with no special case.

Reset
REQ-035 While rst_n=0: a_gnt=b_gnt=0, mem_en=0, mem_wen=0, a_rvalid=b_rvalid=0, last_b=1 (A wins the first contention), state=IDLE.
REQ-036 Reset asserted mid-read SHALL discard the pending read; no rvalid SHALL appear after deassertion.
REQ-037 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-038 Single A read: preload word 5=0xDEADBEEF; a_req=1, a_wen=0, a_addr=5 -> a_gnt same cycle, a_rvalid next cycle with a_rdata=0xDEADBEEF, b_rvalid=0.
REQ-039 Contention after reset: a_req=b_req=1 -> A granted in cycle 0 and B in cycle 1; with both held, grants alternate A,B,A,B over 8 cycles.
REQ-040 Byte write: b_wen=4'b0001, b_addr=3, b_wdata=0x000000AA over existing 0x11223344, then A reads addr 3 -> 0x112233AA; no rvalid on the write.
REQ-041 Back-to-back: A reads addr 1 (0x1), then B reads addr 2 (0x2) in the next cycle -> a_rvalid/0x1 then b_rvalid/0x2 on consecutive cycles.
REQ-042 Reset mid-read: grant an A read, drop rst_n in the next cycle -> all outputs at reset values and no a_rvalid after release.
